axis_to_serial: RTL and testbench
=================================

// Module: axis_to_serial
// PURPOSE
//   Bridge from a 32-bit AXI-Stream master to a serial SPI port (mode 0, this block is the SPI slave).
//   - Accepts words on s_axis_*.
//   - Splits each word into bytes, least-significant byte first, and buffers them in a byte FIFO.
//   - Shifts the bytes out on serial_miso, MSB first, while the external host clocks serial_sck.
//   - serial_rts tells the host that data is waiting.
//   Return path of the serial-to-AXIS receive bridge; sits between the core's result stream and the host link.
// PARAMETERS
//   FIFO_SIZE      4096      byte FIFO depth, power of two, >= 8
//   RTS_THRESHOLD  4         serial_rts asserts when FIFO fill >= this many bytes
//   IDLE_BYTE      8'h00     byte shifted out when the FIFO is empty at a byte boundary
// PORTS
//   aclk           in   1   clock
//   reset          in   1   synchronous, active-high reset
//   s_axis_tvalid  in   1   input word valid
//   s_axis_tready  out  1   input word accepted when tvalid && tready
//   s_axis_tlast   in   1   last word of packet
//   s_axis_tdata   in   32  input word; byte 0 = [7:0], sent first
//   serial_sck     in   1   SPI clock from host (async, mode 0)
//   serial_cs      in   1   SPI select, active-high (async)
//   serial_mosi    in   1   unused; no sink
//   serial_miso    out  1   SPI data to host
//   serial_rts     out  1   data-pending flag to host, registered
// BEHAVIOUR
//   Reset: s_axis_tready=0, serial_miso=0, serial_rts=0. FIFO flushed, packet counter=0, bit counter=0, state IDLE.
//   Write side FSM (states IDLE, BYTE1, BYTE2, BYTE3):
//     IDLE:  tready=1 iff FIFO free >= 4. On handshake:
//            - latch tdata and tlast;
//            - write byte0 with last-flag 0;
//            - go to BYTE1.
//     BYTE1/BYTE2: write byte1 / byte2, flag 0; advance one state per cycle.
//     BYTE3: write byte3 with flag = latched tlast; return to IDLE.
//     tready is 0 in BYTE1..BYTE3. Peak throughput is 1 word per 4 cycles.
//     The free-space check guarantees the FIFO never overflows.
//   FIFO: 9-bit entries {last_flag, byte}, first-word-fall-through read.
//   Packet counter:
//     - +1 when a flagged byte is written; -1 when a flagged byte is popped;
//     - both in the same cycle: unchanged;
//     - width LGFLEN+1, cannot wrap.
//   serial_rts <= (fill >= RTS_THRESHOLD) || (pkt_cnt != 0). Lag of 1 cycle.
//     A short tlast packet is therefore still announced.
//   SPI side:
//     - serial_sck and serial_cs pass through 2-FF synchronizers; edges are detected on the synchronized sck.
//     - serial_sck must be <= aclk/8.
//     cs rise: load shift register from FIFO head, pop 1 byte. If the FIFO is empty, load IDLE_BYTE and do not pop.
//       Bit counter cleared.
//     sck rise: bit counter +1 mod 8.
//     sck fall:
//       - bit counter == 0 (8 bits done): load the next byte (same pop/IDLE rule);
//       - otherwise shift left 1.
//     serial_miso = shift[7] while cs is high, 0 while cs is low.
//     cs fall mid-byte: bit counter cleared; the already-popped partial byte is discarded, not re-sent.
//   Same-cycle FIFO write and SPI pop are both honoured; fill is unchanged.
//   Reset mid-transfer: FIFO, counters and shift register cleared; pending data is lost.
// STRUCTURE
//   Shared package: write-FSM state encodings, SPI_MODE=0, BYTES_PER_WORD=4.
//   Sub-module: existing sfifo instantiated with BW=9, LGFLEN=$clog2(FIFO_SIZE).
//     - i_reset driven directly by reset.
//   Synchronizers, SPI shifter and write FSM stay inline.
// TESTING
//   1. Word 32'h44332211, tlast=0; host clocks 4 bytes -> MISO 11,22,33,44, each MSB first.
//      serial_rts: 1 after the write, 0 after the last pop.
//   2. Host clocks 2 bytes with the FIFO empty -> MISO 00,00 (IDLE_BYTE).
//      FIFO fill and packet counter stay 0.
//   3. Fill to FIFO_SIZE-3 bytes.
//      - tready must stay 0 with tvalid held;
//      - after the host reads 1 byte, tready returns to 1 and the word is accepted;
//      - no byte is lost or duplicated.
//   4. Single word with tlast=1, RTS_THRESHOLD=8.
//      - serial_rts=1 from the pkt_cnt path;
//      - after 4 bytes are read, pkt_cnt=0 and serial_rts=0.
//   5. Drop cs after 3 sck bits of byte 0xA5.
//      - the next cs rise sends the following FIFO byte, not A5;
//      - the bit counter restarts at 0.
//   6. Assert reset during a 2-word burst mid-SPI byte.
//      - all outputs return to reset values the next cycle;
//      - fill=0;
//      - subsequent transfers are correct.

Source files
------------

// File: rtl/axis_to_serial_pkg.sv
// Shared types and constants for the AXI-Stream to SPI-slave return bridge.
`timescale 1ns/1ps
package axis_to_serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BYTE1 = 2'd1,
    ST_BYTE2 = 2'd2,
    ST_BYTE3 = 2'd3
  } wr_state_t;

  localparam int unsigned SPI_MODE       = 0;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BYTE_W         = 8;

  // Byte idx of a 32-bit word, byte 0 = [7:0].
  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
    return w[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/sfifo.sv
// Synchronous first-word-fall-through FIFO with registered fill, empty and full.
`timescale 1ns/1ps
module sfifo #(
  parameter int unsigned BW     = 8,
  parameter int unsigned LGFLEN = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_wr,
  input  logic [BW-1:0]     i_data,
  output logic              o_full,
  output logic [LGFLEN:0]   o_fill,
  input  logic              i_rd,
  output logic [BW-1:0]     o_data,
  output logic              o_empty
);

  localparam int unsigned DEPTH = 1 << LGFLEN;

  logic [BW-1:0]     mem [DEPTH];
  logic [LGFLEN-1:0] wr_addr;
  logic [LGFLEN-1:0] rd_addr;
  logic [LGFLEN:0]   fill_d;
  logic              wr_ok;
  logic              rd_ok;

  assign wr_ok  = i_wr && !o_full;
  assign rd_ok  = i_rd && !o_empty;
  assign o_data = mem[rd_addr];

  always_comb begin
    fill_d = o_fill;
    case ({wr_ok, rd_ok})
      2'b10:   fill_d = o_fill + 1'b1;
      2'b01:   fill_d = o_fill - 1'b1;
      default: fill_d = o_fill;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_addr <= '0;
      rd_addr <= '0;
      o_fill  <= '0;
      o_empty <= 1'b1;
      o_full  <= 1'b0;
    end else begin
      if (wr_ok) wr_addr <= wr_addr + 1'b1;
      if (rd_ok) rd_addr <= rd_addr + 1'b1;
      o_fill  <= fill_d;
      o_empty <= (fill_d == '0);
      o_full  <= (fill_d == (LGFLEN+1)'(DEPTH));
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_ok) mem[wr_addr] <= i_data;
  end

endmodule

// File: rtl/axis_to_serial.sv
// 32-bit AXI-Stream sink feeding a byte FIFO that an external SPI master (mode 0) drains via MISO.
`timescale 1ns/1ps
module axis_to_serial
  import axis_to_serial_pkg::*;
#(
  parameter int unsigned FIFO_SIZE     = 4096,
  parameter int unsigned RTS_THRESHOLD = 4,
  parameter logic [7:0]  IDLE_BYTE     = 8'h00
) (
  input  logic        aclk,
  input  logic        reset,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  input  logic [31:0] s_axis_tdata,
  input  logic        serial_sck,
  input  logic        serial_cs,
  input  logic        serial_mosi,
  output logic        serial_miso,
  output logic        serial_rts
);

  localparam int unsigned LGFLEN = $clog2(FIFO_SIZE);
  localparam int unsigned FILL_W = LGFLEN + 1;
  localparam logic [FILL_W-1:0] READY_MAX = FILL_W'(FIFO_SIZE - BYTES_PER_WORD);
  localparam logic [FILL_W-1:0] RTS_LVL   = FILL_W'(RTS_THRESHOLD);

  wr_state_t         state;
  logic [31:0]       word_q;
  logic              last_q;
  logic              handshake;
  logic              stay_idle;
  logic              ready_d;
  logic              wr_en;
  logic [8:0]        wr_data;

  logic [FILL_W-1:0] fifo_fill;
  logic [8:0]        fifo_rdata;
  logic              fifo_empty;
  logic              fifo_full;
  logic              pop;
  logic [FILL_W-1:0] pkt_cnt;

  logic [2:0]        sck_sync;
  logic [2:0]        cs_sync;
  logic              cs_on;
  logic              cs_rise;
  logic              sck_rise;
  logic              sck_fall;
  logic [2:0]        bit_cnt;
  logic [7:0]        shift_q;
  logic [7:0]        shift_d;
  logic              load;

  logic              unused_inputs;
  assign unused_inputs = ^{serial_mosi, fifo_full};

  assign handshake = s_axis_tvalid && s_axis_tready;
  assign stay_idle = (state == ST_BYTE3) || ((state == ST_IDLE) && !handshake);
  // Pops only add space, so counting this cycle's write alone keeps tready safe.
  assign ready_d   = stay_idle && ((fifo_fill + FILL_W'(wr_en)) <= READY_MAX);

  always_comb begin
    wr_en   = 1'b0;
    wr_data = '0;
    unique case (state)
      ST_IDLE: begin
        wr_en   = handshake;
        wr_data = {1'b0, word_byte(s_axis_tdata, 2'd0)};
      end
      ST_BYTE1: begin
        wr_en   = 1'b1;
        wr_data = {1'b0, word_byte(word_q, 2'd1)};
      end
      ST_BYTE2: begin
        wr_en   = 1'b1;
        wr_data = {1'b0, word_byte(word_q, 2'd2)};
      end
      ST_BYTE3: begin
        wr_en   = 1'b1;
        wr_data = {last_q, word_byte(word_q, 2'd3)};
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      state         <= ST_IDLE;
      word_q        <= '0;
      last_q        <= 1'b0;
      s_axis_tready <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (handshake) begin
            word_q <= s_axis_tdata;
            last_q <= s_axis_tlast;
            state  <= ST_BYTE1;
          end
        end
        ST_BYTE1: state <= ST_BYTE2;
        ST_BYTE2: state <= ST_BYTE3;
        ST_BYTE3: state <= ST_IDLE;
      endcase
      s_axis_tready <= ready_d;
    end
  end

  sfifo #(
    .BW     (9),
    .LGFLEN (LGFLEN)
  ) u_fifo (
    .i_clk   (aclk),
    .i_reset (reset),
    .i_wr    (wr_en),
    .i_data  (wr_data),
    .o_full  (fifo_full),
    .o_fill  (fifo_fill),
    .i_rd    (pop),
    .o_data  (fifo_rdata),
    .o_empty (fifo_empty)
  );

  assign cs_on    = cs_sync[1];
  assign cs_rise  = cs_sync[1] && !cs_sync[2];
  assign sck_rise = cs_on && sck_sync[1] && !sck_sync[2];
  assign sck_fall = cs_on && !sck_sync[1] && sck_sync[2];
  assign load     = cs_rise || (sck_fall && (bit_cnt == 3'd0));
  assign pop      = load && !fifo_empty;

  // Next shift contents; an empty FIFO at a byte boundary yields the idle byte.
  always_comb begin
    shift_d = shift_q;
    if (load) begin
      shift_d = fifo_empty ? IDLE_BYTE : fifo_rdata[7:0];
    end else if (sck_fall) begin
      shift_d = {shift_q[6:0], 1'b0};
    end
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      sck_sync    <= '0;
      cs_sync     <= '0;
      bit_cnt     <= '0;
      shift_q     <= '0;
      serial_miso <= 1'b0;
    end else begin
      sck_sync <= {sck_sync[1:0], serial_sck};
      cs_sync  <= {cs_sync[1:0], serial_cs};
      if (!cs_on || cs_rise) begin
        bit_cnt <= '0;
      end else if (sck_rise) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
      shift_q     <= shift_d;
      serial_miso <= cs_on && shift_d[7];
    end
  end

  // Counts whole packets resident in the FIFO so a short final packet still raises rts.
  always_ff @(posedge aclk) begin
    if (reset) begin
      pkt_cnt    <= '0;
      serial_rts <= 1'b0;
    end else begin
      unique case ({wr_en && wr_data[8], pop && fifo_rdata[8]})
        2'b10:   pkt_cnt <= pkt_cnt + 1'b1;
        2'b01:   pkt_cnt <= pkt_cnt - 1'b1;
        default: pkt_cnt <= pkt_cnt;
      endcase
      serial_rts <= (fifo_fill >= RTS_LVL) || (pkt_cnt != '0);
    end
  end

endmodule

// File: tb/tb_axis_to_serial.sv
// Bench for axis_to_serial: byte scoreboard filled at AXIS handshakes, drained by a modelled SPI host.
`timescale 1ns/1ps
module tb_axis_to_serial;

  localparam int unsigned FSZ  = 16;
  localparam int          HALF = 6;

  logic        aclk = 1'b0;
  logic        reset;
  logic        tvalid;
  logic        tlast;
  logic [31:0] tdata;
  logic        sck;
  logic        cs;
  logic        mosi;
  logic        tready;
  logic        miso;
  logic        rts;
  logic        rts8;
  logic        tready8_unused;
  logic        miso8_unused;

  int n_pass   = 0;
  int n_checks = 0;

  logic [8:0] sb_q[$];

  always #5 aclk = ~aclk;

  axis_to_serial #(.FIFO_SIZE(FSZ), .RTS_THRESHOLD(4), .IDLE_BYTE(8'h00)) dut (
    .aclk(aclk), .reset(reset),
    .s_axis_tvalid(tvalid), .s_axis_tready(tready), .s_axis_tlast(tlast), .s_axis_tdata(tdata),
    .serial_sck(sck), .serial_cs(cs), .serial_mosi(mosi),
    .serial_miso(miso), .serial_rts(rts)
  );

  axis_to_serial #(.FIFO_SIZE(FSZ), .RTS_THRESHOLD(8), .IDLE_BYTE(8'h00)) dut8 (
    .aclk(aclk), .reset(reset),
    .s_axis_tvalid(tvalid), .s_axis_tready(tready8_unused), .s_axis_tlast(tlast), .s_axis_tdata(tdata),
    .serial_sck(sck), .serial_cs(cs), .serial_mosi(mosi),
    .serial_miso(miso8_unused), .serial_rts(rts8)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge aclk);
  endtask

  function automatic logic [8:0] sb_pop();
    if (sb_q.size() == 0) return 9'h000;
    return sb_q.pop_front();
  endfunction

  function automatic logic exp_rts(input int th);
    int flags = 0;
    foreach (sb_q[i]) if (sb_q[i][8]) flags++;
    return (sb_q.size() >= th) || (flags != 0);
  endfunction

  task automatic send_word(input logic [31:0] d, input logic l, input int budget);
    bit done = 1'b0;
    @(negedge aclk);
    tvalid = 1'b1; tdata = d; tlast = l;
    for (int i = 0; i < budget && !done; i++) begin
      if (tready) begin
        @(posedge aclk);
        for (int b = 0; b < 4; b++) sb_q.push_back({(b == 3) ? l : 1'b0, d[8*b +: 8]});
        done = 1'b1;
      end
      @(negedge aclk);
    end
    tvalid = 1'b0;
    check("axis_handshake", 32'(done), 32'd1);
  endtask

  // Host clocks nbits; a byte is taken from the FIFO at cs rise and after every 8th bit.
  task automatic spi_xfer(input int nbits);
    logic [8:0] cur;
    logic [7:0] rx;
    int k;
    @(negedge aclk);
    cs = 1'b1;
    cur = sb_pop();
    rx = '0;
    k = 0;
    cyc(HALF);
    for (int b = 0; b < nbits; b++) begin
      rx = {rx[6:0], miso};
      k++;
      sck = 1'b1; cyc(HALF);
      sck = 1'b0; cyc(HALF);
      if (k == 8) begin
        check("spi_byte", 32'(rx), 32'(cur[7:0]));
        cur = sb_pop();
        rx = '0;
        k = 0;
      end
    end
    if (k != 0) check("spi_partial", 32'(rx), 32'(8'(cur[7:0] >> (8 - k))));
    cs = 1'b0;
    cyc(HALF);
    check("miso_cs_low", 32'(miso), 32'd0);
  endtask

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic        rts4;
    logic        rts8;
  } vec_t;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[4];
    vecs[0] = '{32'h44332211, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{32'hA1B2C3D4, 1'b1, 1'b1, 1'b1};
    vecs[2] = '{32'h00000000, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{32'hDEADBEEF, 1'b1, 1'b1, 1'b1};

    reset = 1'b1; tvalid = 1'b0; tlast = 1'b0; tdata = '0;
    sck = 1'b0; cs = 1'b0; mosi = 1'b0;
    cyc(3);
    check("reset_tready", 32'(tready), 32'd0);
    check("reset_miso", 32'(miso), 32'd0);
    check("reset_rts", 32'(rts), 32'd0);
    check("reset_rts8", 32'(rts8), 32'd0);
    reset = 1'b0;
    cyc(3);
    check("tready_after_reset", 32'(tready), 32'd1);

    // Single words, LSB byte first, rts through fill or packet path.
    for (int i = 0; i < 4; i++) begin
      send_word(vecs[i].data, vecs[i].last, 200);
      cyc(8);
      check("rts_after_write", 32'(rts), 32'(vecs[i].rts4));
      check("rts8_after_write", 32'(rts8), 32'(vecs[i].rts8));
      spi_xfer(32);
      cyc(4);
      check("rts_after_drain", 32'(rts), 32'(exp_rts(4)));
      check("rts8_after_drain", 32'(rts8), 32'(exp_rts(8)));
    end

    // Empty FIFO shifts idle bytes and leaves state untouched.
    spi_xfer(16);
    cyc(4);
    check("empty_rts", 32'(rts), 32'd0);
    check("empty_rts8", 32'(rts8), 32'd0);
    check("empty_tready", 32'(tready), 32'd1);

    // Near-full backpressure.
    for (int i = 0; i < 4; i++) send_word(32'h10203040 + 32'(i) * 32'h01010101, 1'b0, 200);
    cyc(8);
    check("full_tready", 32'(tready), 32'd0);
    spi_xfer(16);
    cyc(4);
    @(negedge aclk);
    tvalid = 1'b1; tdata = 32'hC0FFEE99; tlast = 1'b0;
    cyc(12);
    check("fill13_tready_blocked", 32'(tready), 32'd0);
    fork
      send_word(32'hC0FFEE99, 1'b0, 400);
      spi_xfer(8);
    join
    cyc(8);
    spi_xfer(sb_q.size() * 8);
    spi_xfer(8);
    cyc(4);
    check("drain_rts", 32'(rts), 32'd0);

    // cs dropped mid-byte: partial byte discarded, bit count restarts.
    send_word(32'h3CC35AA5, 1'b0, 200);
    cyc(8);
    spi_xfer(3);
    spi_xfer(8);
    spi_xfer(8);
    cyc(4);
    check("abort_rts", 32'(rts), 32'd0);

    // Reset in the middle of an SPI byte with two words queued.
    send_word(32'h0F1E2D3C, 1'b0, 200);
    send_word(32'h4B5A6978, 1'b1, 200);
    @(negedge aclk);
    cs = 1'b1;
    cyc(HALF);
    repeat (3) begin
      sck = 1'b1; cyc(HALF);
      sck = 1'b0; cyc(HALF);
    end
    sck = 1'b1;
    cyc(2);
    reset = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    check("midreset_tready", 32'(tready), 32'd0);
    check("midreset_miso", 32'(miso), 32'd0);
    check("midreset_rts", 32'(rts), 32'd0);
    check("midreset_rts8", 32'(rts8), 32'd0);
    cs = 1'b0; sck = 1'b0;
    cyc(2);
    reset = 1'b0;
    sb_q.delete();
    cyc(4);
    check("postreset_tready", 32'(tready), 32'd1);
    check("postreset_rts", 32'(rts), 32'd0);
    send_word(32'h87654321, 1'b1, 200);
    cyc(8);
    check("postreset_rts8", 32'(rts8), 32'd1);
    spi_xfer(32);
    cyc(4);
    check("postreset_drain_rts8", 32'(rts8), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
